// File: rtl/dsp_stream_pkg.sv
// ---------------------------------------------------------------------------
// dsp_stream_pkg
// Shared types for the DSP stream output buffer.
//   BEAT_DATA_WIDTH : sample width carried in every stored beat
//   stream_beat_t   : one FIFO entry {sop, eop, data}
//   framing_state_t : packet framing tracker states
// ---------------------------------------------------------------------------
package dsp_stream_pkg;

    localparam int BEAT_DATA_WIDTH = 32;

    typedef struct packed {
        logic                       sop;
        logic                       eop;
        logic [BEAT_DATA_WIDTH-1:0] data;
    } stream_beat_t;

    typedef enum logic {
        IDLE   = 1'b0,
        IN_PKT = 1'b1
    } framing_state_t;

endpackage

// File: rtl/dsp_stream_output_buffer_if.sv
// ---------------------------------------------------------------------------
// dsp_stream_output_buffer_if
// Bundles every non-clock signal of the output buffer.
//   slave  : buffer view (receives pipeline beats, sources the Avalon-ST out)
//   master : environment view (upstream producer, delay line, downstream sink)
// Signals:
//   avalon_streaming_sink_valid  upstream beat offered
//   buffer_sink_ready            credit-based ready toward upstream
//   pipeline_*                   delayed qualifiers and DSP result
//   avalon_streaming_source_*    Avalon-ST source toward downstream
//   overflow_error/framing_error sticky status flags
// ---------------------------------------------------------------------------
interface dsp_stream_output_buffer_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  avalon_streaming_sink_valid;
    logic                  buffer_sink_ready;
    logic                  pipeline_valid;
    logic                  pipeline_startofpacket;
    logic                  pipeline_endofpacket;
    logic [DATA_WIDTH-1:0] pipeline_data;
    logic                  avalon_streaming_source_ready;
    logic                  avalon_streaming_source_valid;
    logic [DATA_WIDTH-1:0] avalon_streaming_source_data;
    logic                  avalon_streaming_source_startofpacket;
    logic                  avalon_streaming_source_endofpacket;
    logic                  overflow_error;
    logic                  framing_error;

    modport slave (
        input  avalon_streaming_sink_valid,
        input  pipeline_valid,
        input  pipeline_startofpacket,
        input  pipeline_endofpacket,
        input  pipeline_data,
        input  avalon_streaming_source_ready,
        output buffer_sink_ready,
        output avalon_streaming_source_valid,
        output avalon_streaming_source_data,
        output avalon_streaming_source_startofpacket,
        output avalon_streaming_source_endofpacket,
        output overflow_error,
        output framing_error
    );

    modport master (
        output avalon_streaming_sink_valid,
        output pipeline_valid,
        output pipeline_startofpacket,
        output pipeline_endofpacket,
        output pipeline_data,
        output avalon_streaming_source_ready,
        input  buffer_sink_ready,
        input  avalon_streaming_source_valid,
        input  avalon_streaming_source_data,
        input  avalon_streaming_source_startofpacket,
        input  avalon_streaming_source_endofpacket,
        input  overflow_error,
        input  framing_error
    );
endinterface

// File: rtl/dsp_stream_output_buffer_ram.sv
// ---------------------------------------------------------------------------
// output_buffer_ram
// Simple dual-port register array: synchronous write, asynchronous read.
// Ports:
//   clk      in   system clock
//   wr_en    in   write strobe
//   wr_addr  in   write address
//   wr_beat  in   beat to store
//   rd_addr  in   read address
//   rd_beat  out  beat at rd_addr (combinational)
// Contents are not reset; the owner qualifies reads with its own occupancy.
// ---------------------------------------------------------------------------
module output_buffer_ram
    import dsp_stream_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  stream_beat_t          wr_beat,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output stream_beat_t          rd_beat
);

    stream_beat_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_beat;
        end
    end

    assign rd_beat = mem[rd_addr];

endmodule

// File: rtl/dsp_stream_output_buffer.sv
// ---------------------------------------------------------------------------
// dsp_stream_output_buffer
// Captures pipeline beats into a show-ahead FIFO, presents them as an
// Avalon-ST source with backpressure, and issues credit-based ready upstream
// so that beats still travelling through the fixed-latency pipeline always
// find room in the FIFO.
// Ports:
//   clk    in  system clock
//   rst_n  in  asynchronous active-low reset
//   bus    slave modport of dsp_stream_output_buffer_if (all stream signals)
//
// Framing tracker states:
//   state  | meaning
//   IDLE   | between packets, next accepted beat must carry SOP
//   IN_PKT | inside a packet, waiting for EOP
// ---------------------------------------------------------------------------
module dsp_stream_output_buffer
    import dsp_stream_pkg::*;
#(
    parameter int DATA_WIDTH   = BEAT_DATA_WIDTH,
    parameter int DEPTH        = 16,
    parameter int PIPE_LATENCY = 5
) (
    input logic                       clk,
    input logic                       rst_n,
    dsp_stream_output_buffer_if.slave bus
);

    localparam int ADDR_WIDTH = $clog2(DEPTH);
    localparam int CNT_WIDTH  = $clog2(DEPTH + 1);

    // Elaboration-time guards on the configuration.
    if (DATA_WIDTH != BEAT_DATA_WIDTH) begin : g_bad_width
        $error("DATA_WIDTH must equal the package beat width");
    end
    if ((DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth_pow2
        $error("DEPTH must be a power of two");
    end
    if (DEPTH < PIPE_LATENCY + 2) begin : g_bad_depth_latency
        $error("DEPTH too small to cover pipeline latency");
    end

    logic [ADDR_WIDTH-1:0] wr_ptr_q;
    logic [ADDR_WIDTH-1:0] rd_ptr_q;
    logic [CNT_WIDTH-1:0]  count_q;
    logic [CNT_WIDTH-1:0]  count_nxt;
    logic [CNT_WIDTH-1:0]  inflight_q;
    logic [CNT_WIDTH-1:0]  inflight_nxt;
    logic [CNT_WIDTH:0]    occupancy_nxt;
    logic                  ready_q;
    logic                  ready_nxt;
    logic                  overflow_q;
    logic                  framing_q;
    logic                  framing_set;
    framing_state_t        state_q;
    framing_state_t        state_nxt;

    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  wr_en;
    logic                  rd_en;
    logic                  overflow_set;
    logic                  inflight_inc;
    logic                  inflight_dec;
    stream_beat_t          wr_beat;
    stream_beat_t          head_beat;

    assign fifo_full    = (count_q == CNT_WIDTH'(DEPTH));
    assign fifo_empty   = (count_q == '0);
    // A full FIFO refuses the write even when a pop frees a slot this cycle.
    assign wr_en        = bus.pipeline_valid && !fifo_full;
    assign overflow_set = bus.pipeline_valid && fifo_full;
    assign rd_en        = !fifo_empty && bus.avalon_streaming_source_ready;

    assign inflight_inc = bus.avalon_streaming_sink_valid && ready_q;
    assign inflight_dec = bus.pipeline_valid;

    assign wr_beat.sop  = bus.pipeline_startofpacket;
    assign wr_beat.eop  = bus.pipeline_endofpacket;
    assign wr_beat.data = bus.pipeline_data;

    output_buffer_ram #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr_q),
        .wr_beat (wr_beat),
        .rd_addr (rd_ptr_q),
        .rd_beat (head_beat)
    );

    always_comb begin
        count_nxt = count_q;
        if (wr_en && !rd_en) begin
            count_nxt = count_q + CNT_WIDTH'(1);
        end else if (!wr_en && rd_en) begin
            count_nxt = count_q - CNT_WIDTH'(1);
        end
    end

    // Stray pipeline_valid with nothing in flight must not wrap the counter.
    always_comb begin
        inflight_nxt = inflight_q;
        if (inflight_inc && !inflight_dec) begin
            inflight_nxt = inflight_q + CNT_WIDTH'(1);
        end else if (!inflight_inc && inflight_dec && (inflight_q != '0)) begin
            inflight_nxt = inflight_q - CNT_WIDTH'(1);
        end
    end

    // Credit looks at next-cycle occupancy so the registered ready never
    // lets more than DEPTH beats be outstanding.
    assign occupancy_nxt = {1'b0, count_nxt} + {1'b0, inflight_nxt};
    assign ready_nxt     = (occupancy_nxt < (CNT_WIDTH + 1)'(DEPTH));

    always_comb begin
        state_nxt   = state_q;
        framing_set = 1'b0;
        if (wr_en) begin
            case (state_q)
                IDLE: begin
                    if (!wr_beat.sop) begin
                        framing_set = 1'b1;
                    end else if (!wr_beat.eop) begin
                        state_nxt = IN_PKT;
                    end
                end
                IN_PKT: begin
                    // An unexpected SOP is flagged but treated as a new packet.
                    if (wr_beat.sop) begin
                        framing_set = 1'b1;
                    end
                    if (wr_beat.eop) begin
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            inflight_q <= '0;
            ready_q    <= 1'b0;
            overflow_q <= 1'b0;
            framing_q  <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + ADDR_WIDTH'(1);
            end
            if (rd_en) begin
                rd_ptr_q <= rd_ptr_q + ADDR_WIDTH'(1);
            end
            count_q    <= count_nxt;
            inflight_q <= inflight_nxt;
            ready_q    <= ready_nxt;
            if (overflow_set) begin
                overflow_q <= 1'b1;
            end
            if (framing_set) begin
                framing_q <= 1'b1;
            end
        end
    end

    // Head fields are forced to zero while empty so stale RAM contents never
    // leak onto the source and all outputs read zero out of reset.
    assign bus.avalon_streaming_source_valid         = !fifo_empty;
    assign bus.avalon_streaming_source_data          = fifo_empty ? '0   : head_beat.data;
    assign bus.avalon_streaming_source_startofpacket = fifo_empty ? 1'b0 : head_beat.sop;
    assign bus.avalon_streaming_source_endofpacket   = fifo_empty ? 1'b0 : head_beat.eop;
    assign bus.buffer_sink_ready                     = ready_q;
    assign bus.overflow_error                        = overflow_q;
    assign bus.framing_error                         = framing_q;

endmodule
